// File: rtl/present_pkg.sv
// Shared widths, controller state encoding and PRESENT-80 known-answer vectors.
package present_pkg;

  localparam int KEY_W = 80;
  localparam int BLK_W = 64;
  localparam int KAT_N = 4;

  typedef enum logic [2:0] {IDLE, KEY, DATA, RUN, OUT} ctrl_state_t;

  function automatic logic [KEY_W-1:0] kat_key(input int idx);
    case (idx)
      1, 3:    kat_key = {KEY_W{1'b1}};
      default: kat_key = '0;
    endcase
  endfunction

  function automatic logic [BLK_W-1:0] kat_pt(input int idx);
    case (idx)
      2, 3:    kat_pt = {BLK_W{1'b1}};
      default: kat_pt = '0;
    endcase
  endfunction

  function automatic logic [BLK_W-1:0] kat_ct(input int idx);
    case (idx)
      1:       kat_ct = 64'hE72C46C0F5945049;
      2:       kat_ct = 64'hA112FFC72F68417B;
      3:       kat_ct = 64'h3333DCD3213210D2;
      default: kat_ct = 64'h5579C1387B228445;
    endcase
  endfunction

endpackage

// File: rtl/present_ct_fifo.sv
// Two-entry FIFO holding finished ciphertexts until downstream takes them.
// A push while full or a pop while empty is ignored.
module present_ct_fifo #(
  parameter int WIDTH = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_vld,
  output logic [1:0]       o_cnt
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_cnt != 2'd2);
  assign w_pop  = i_pop && (r_cnt != 2'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dat = r_mem[r_rd_ptr];
  assign o_vld = (r_cnt != 2'd0);
  assign o_cnt = r_cnt;

endmodule

// File: rtl/present_stream_ctrl.sv
// Feeds keys and plaintexts to the handshake-less PRESENT core, times its fixed latency, returns ciphertexts.
// PRESENT_CT_FIFO_EN: a 2-entry ciphertext FIFO replaces the single OUT holding register.
module present_stream_ctrl
  import present_pkg::*;
#(
  parameter int  ROUND_CYCLES = 32,
  localparam int CNT_W        = $clog2(ROUND_CYCLES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  input  logic [BLK_W-1:0] pt_i,
  input  logic             pt_valid_i,
  output logic             pt_ready_o,
  output logic [BLK_W-1:0] ct_o,
  output logic             ct_valid_o,
  input  logic             ct_ready_i,
  output logic [KEY_W-1:0] core_data_o,
  output logic             core_key_load_o,
  output logic             core_data_load_o,
  input  logic [BLK_W-1:0] core_data_i
);

  if (ROUND_CYCLES < 1) begin : g_bad_round_cycles
    $error("present_stream_ctrl: ROUND_CYCLES must be at least 1");
  end

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_nxt;
  logic [KEY_W-1:0] r_key;
  logic [BLK_W-1:0] r_pt;
  logic [KEY_W-1:0] r_core_dat;
  logic [KEY_W-1:0] w_core_dat;
  logic             r_key_loaded;
  logic [CNT_W-1:0] r_cnt;
  logic             w_key_rdy;
  logic             w_pt_rdy;
  logic             w_key_hs;
  logic             w_pt_hs;
  logic             w_ct_hs;
  logic             w_capture;
  logic             w_space;

`ifdef PRESENT_CT_FIFO_EN
  logic [1:0] w_fifo_cnt;

  // Accept a block only if its result is guaranteed a FIFO slot.
  assign w_space = (w_fifo_cnt <= 2'd1);

  present_ct_fifo #(
    .WIDTH(BLK_W)
  ) u_ct_fifo (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_push    (w_capture),
    .i_push_dat(core_data_i),
    .i_pop     (w_ct_hs),
    .o_dat     (ct_o),
    .o_vld     (ct_valid_o),
    .o_cnt     (w_fifo_cnt)
  );
`else
  logic [BLK_W-1:0] r_ct;

  assign w_space    = 1'b1;
  assign ct_valid_o = (r_state == OUT);
  assign ct_o       = r_ct;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ct <= '0;
    end else if (w_capture) begin
      r_ct <= core_data_i;
    end
  end
`endif

  assign w_ct_hs  = ct_valid_o && ct_ready_i;
  assign w_key_hs = key_valid_i && w_key_rdy;
  assign w_pt_hs  = pt_valid_i && w_pt_rdy;

  always_comb begin
    w_state_nxt      = r_state;
    w_key_rdy        = 1'b0;
    w_pt_rdy         = 1'b0;
    w_core_dat       = r_core_dat;
    core_key_load_o  = 1'b0;
    core_data_load_o = 1'b0;
    w_capture        = 1'b0;
    case (r_state)
      IDLE: begin
        w_key_rdy = 1'b1;
        w_pt_rdy  = r_key_loaded && !key_valid_i && w_space;
        if (key_valid_i) begin
          w_state_nxt = KEY;
        end else if (pt_valid_i && w_pt_rdy) begin
          w_state_nxt = DATA;
        end
      end
      KEY: begin
        w_core_dat      = r_key;
        core_key_load_o = 1'b1;
        w_state_nxt     = IDLE;
      end
      DATA: begin
        w_core_dat       = {{(KEY_W - BLK_W){1'b0}}, r_pt};
        core_data_load_o = 1'b1;
        w_state_nxt      = RUN;
      end
      RUN: begin
        // Core output is final in the cycle the counter reaches zero.
        if (r_cnt == '0) begin
          w_capture = 1'b1;
`ifdef PRESENT_CT_FIFO_EN
          w_state_nxt = IDLE;
`else
          w_state_nxt = OUT;
`endif
        end
      end
      OUT: begin
        if (w_ct_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign key_ready_o = w_key_rdy;
  assign pt_ready_o  = w_pt_rdy;
  assign core_data_o = w_core_dat;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_key        <= '0;
      r_pt         <= '0;
      r_core_dat   <= '0;
      r_key_loaded <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_core_dat <= w_core_dat;
      if (w_key_hs) begin
        r_key <= key_i;
      end
      if (w_pt_hs) begin
        r_pt <= pt_i;
      end
      if (r_state == KEY) begin
        r_key_loaded <= 1'b1;
      end
      if (r_state == DATA) begin
        r_cnt <= CNT_W'(ROUND_CYCLES - 1);
      end else if ((r_state == RUN) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_present_stream_ctrl.sv
// Bench for present_stream_ctrl: a stand-in core returns known answers exactly ROUND_CYCLES after data_load;
// a scoreboard queue is filled at plaintext handshake and drained by a ciphertext monitor.
module tb_present_stream_ctrl;
  import present_pkg::*;

  localparam int RC  = 32;
  localparam int LAT = 34;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [KEY_W-1:0] key = '0;
  logic             key_valid = 1'b0;
  logic             key_ready;
  logic [BLK_W-1:0] pt = '0;
  logic             pt_valid = 1'b0;
  logic             pt_ready;
  logic [BLK_W-1:0] ct;
  logic             ct_valid;
  logic             ct_ready = 1'b1;
  logic [KEY_W-1:0] core_data;
  logic             core_key_load;
  logic             core_data_load;
  logic [BLK_W-1:0] core_din;

  always #5 clk = ~clk;

  present_stream_ctrl #(.ROUND_CYCLES(RC)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .key_i           (key),
    .key_valid_i     (key_valid),
    .key_ready_o     (key_ready),
    .pt_i            (pt),
    .pt_valid_i      (pt_valid),
    .pt_ready_o      (pt_ready),
    .ct_o            (ct),
    .ct_valid_o      (ct_valid),
    .ct_ready_i      (ct_ready),
    .core_data_o     (core_data),
    .core_key_load_o (core_key_load),
    .core_data_load_o(core_data_load),
    .core_data_i     (core_din)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  logic [BLK_W-1:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no response within bound, required one", name);
  endtask

  // Stand-in core: final ciphertext on its output only in the cycle the controller must capture it.
  logic [KEY_W-1:0] core_key_q = '0;
  logic [BLK_W-1:0] core_pt_q = '0;
  int run_cnt = -1;
  int key_load_cyc = -1;
  int data_load_cyc = -1;
  int strobe_cnt = 0;

  function automatic logic [BLK_W-1:0] core_result(input logic [KEY_W-1:0] k, input logic [BLK_W-1:0] p);
    core_result = 64'hBADC_0DE0_BADC_0DE0;
    for (int i = 0; i < KAT_N; i++)
      if (k == kat_key(i) && p == kat_pt(i)) core_result = kat_ct(i);
  endfunction

  always @(negedge clk) begin
    if (core_key_load || core_data_load) strobe_cnt++;
    if (core_key_load) begin
      core_key_q   = core_data;
      key_load_cyc = cyc;
    end
    if (rst) begin
      run_cnt = -1;
    end else if (core_data_load) begin
      core_pt_q     = core_data[BLK_W-1:0];
      data_load_cyc = cyc;
      run_cnt       = 0;
      check("load_pad", 80'(core_data[KEY_W-1:BLK_W]), 80'(0));
    end else if (run_cnt >= 0) begin
      run_cnt++;
    end
    core_din = (run_cnt == RC) ? core_result(core_key_q, core_pt_q)
                               : (64'hDEAD_BEEF_0000_0000 | 64'(run_cnt & 32'hFFFF));
  end

  always @(negedge clk) begin
    if (!rst && ct_valid && ct_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ct_unexpected: got 'h%0h, required no ciphertext", ct);
      end else begin
        check("ct_value", 80'(ct), 80'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_key(input int idx);
    bit ok = 1'b0;
    @(posedge clk); #1;
    key = kat_key(idx);
    key_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (key_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    key_valid = 1'b0;
    if (!ok) timeout("key_handshake");
  endtask

  task automatic send_pt(input int idx, output int hs);
    hs = -1;
    @(posedge clk); #1;
    pt = kat_pt(idx);
    pt_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (pt_ready) begin
        hs = cyc;
        exp_q.push_back(kat_ct(idx));
        break;
      end
    end
    @(posedge clk); #1;
    pt_valid = 1'b0;
    if (hs < 0) timeout("pt_handshake");
  endtask

  task automatic wait_ct(input int hs, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ct_valid) begin seen = 1'b1; break; end
    end
    if (!seen) timeout({name, "_ct_valid"});
    else check({name, "_latency"}, 80'(cyc - hs), 80'(LAT));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs;
    int snap;
    int nrdy;
    int nchg;
    int nlow;
    logic [BLK_W-1:0] held;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_core_data", 80'(core_data), 80'(0));
    check("rst_key_load", 80'(core_key_load), 80'(0));
    check("rst_data_load", 80'(core_data_load), 80'(0));
    check("rst_ct", 80'(ct), 80'(0));
    check("rst_ct_valid", 80'(ct_valid), 80'(0));
    check("rst_key_ready", 80'(key_ready), 80'(1));
    check("rst_pt_ready", 80'(pt_ready), 80'(0));

    for (int i = 0; i < KAT_N; i++) begin
      send_key(i);
      send_pt(i, hs);
      wait_ct(hs, "kat");
      @(negedge clk);
      check("kat_valid_drop", 80'(ct_valid), 80'(0));
    end

    // Plaintext without a loaded key must stall.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    snap = strobe_cnt;
    nrdy = 0;
    pt = kat_pt(0);
    pt_valid = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (pt_ready) nrdy++;
    end
    check("nokey_pt_ready", 80'(nrdy), 80'(0));
    check("nokey_strobes", 80'(strobe_cnt - snap), 80'(0));

    @(posedge clk); #1;
    key = kat_key(0);
    key_valid = 1'b1;
    @(negedge clk);
    check("prio_pt_ready", 80'(pt_ready), 80'(0));
    check("prio_key_ready", 80'(key_ready), 80'(1));
    @(posedge clk); #1 key_valid = 1'b0;
    send_pt(0, hs);
    wait_ct(hs, "prio");
    check("prio_key_first", 80'(key_load_cyc > 0 && key_load_cyc < data_load_cyc), 80'(1));

    // Downstream backpressure.
    @(posedge clk); #1 ct_ready = 1'b0;
    send_pt(0, hs);
    wait_ct(hs, "bp");
    held = ct;
    nchg = 0;
    nlow = 0;
    nrdy = 0;
    repeat (20) begin
      @(negedge clk);
      if (ct !== held) nchg++;
      if (!ct_valid) nlow++;
      if (pt_ready) nrdy++;
    end
    check("bp_ct_stable", 80'(nchg), 80'(0));
    check("bp_valid_held", 80'(nlow), 80'(0));
`ifndef PRESENT_CT_FIFO_EN
    check("bp_pt_ready", 80'(nrdy), 80'(0));
`endif
    snap = hs_cnt;
    @(posedge clk); #1 ct_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_drop", 80'(ct_valid), 80'(0));
    repeat (5) @(negedge clk);
    check("bp_single_hs", 80'(hs_cnt - snap), 80'(1));

    // Reset in the middle of RUN aborts the block.
    send_pt(2, hs);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    check("abort_core_data", 80'(core_data), 80'(0));
    check("abort_key_load", 80'(core_key_load), 80'(0));
    check("abort_data_load", 80'(core_data_load), 80'(0));
    check("abort_ct", 80'(ct), 80'(0));
    check("abort_ct_valid", 80'(ct_valid), 80'(0));
    @(posedge clk); #1 rst = 1'b0;
    pt = kat_pt(2);
    pt_valid = 1'b1;
    nrdy = 0;
    nlow = 0;
    repeat (40) begin
      @(negedge clk);
      if (pt_ready) nrdy++;
      if (ct_valid) nlow++;
    end
    check("abort_pt_refused", 80'(nrdy), 80'(0));
    check("abort_no_ct", 80'(nlow), 80'(0));
    @(posedge clk); #1 pt_valid = 1'b0;
    send_key(3);
    send_pt(3, hs);
    wait_ct(hs, "recover");

`ifdef PRESENT_CT_FIFO_EN
    // Two results buffer, the third plaintext waits.
    @(posedge clk); #1 ct_ready = 1'b0;
    send_pt(1, hs);
    send_pt(3, hs);
    pt = kat_pt(1);
    pt_valid = 1'b1;
    nrdy = 0;
    repeat (80) begin
      @(negedge clk);
      if (pt_ready) nrdy++;
    end
    check("fifo_third_stalls", 80'(nrdy), 80'(0));
    check("fifo_held_count", 80'(exp_q.size()), 80'(2));
    @(posedge clk); #1;
    pt_valid = 1'b0;
    ct_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("fifo_drained", 80'(exp_q.size()), 80'(0));
    send_pt(1, hs);
    wait_ct(hs, "fifo_third");
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 80'(exp_q.size()), 80'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/present_stream_ctrl.md
Name: present_stream_ctrl

Overview:
- Upstream sequencer and result collector for present_encryptor_top, which has no handshake and no done flag.
- Accepts 80-bit keys and 64-bit plaintext blocks over valid/ready interfaces.
- Drives the core's shared data bus together with its key_load and data_load strobes.
- Counts the fixed core latency, captures data_o as ciphertext, and presents it on a valid/ready output.

Parameters:
- ROUND_CYCLES, 32: clock cycles from the end of the data_load cycle until core data_o holds the final ciphertext.
- CNT_W, $clog2(ROUND_CYCLES+1): width of the round counter. Derived; do not override.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- key_i  in  80  key
- key_valid_i  in  1  key offered
- key_ready_o  out  1  key accepted when key_valid_i && key_ready_o
- pt_i  in  64  plaintext
- pt_valid_i  in  1  plaintext offered
- pt_ready_o  out  1  plaintext accepted on handshake
- ct_o  out  64  ciphertext
- ct_valid_o  out  1  ciphertext available
- ct_ready_i  in  1  downstream consumes ciphertext
- core_data_o  out  80  to core data_i
- core_key_load_o  out  1  to core key_load
- core_data_load_o  out  1  to core data_load
- core_data_i  in  64  from core data_o

Behaviour:
- Interface (already decided): one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset values:
  - core_data_o = 0, core_key_load_o = 0, core_data_load_o = 0
  - ct_o = 0, ct_valid_o = 0
  - key_loaded flag = 0, counter = 0, state = IDLE
- Reset asserted mid-operation aborts any encryption; no ciphertext is emitted for it.
- FSM states: IDLE, KEY, DATA, RUN, OUT.
- IDLE:
  - key_ready_o = 1.
  - pt_ready_o = key_loaded && !key_valid_i. Key has priority when both are valid.
  - On key handshake: register key; next state KEY.
  - On pt handshake: register pt; next state DATA.
- KEY (one cycle):
  - core_data_o = key register, core_key_load_o = 1.
  - Set key_loaded. Next state IDLE.
- DATA (one cycle):
  - core_data_o = {16'h0000, pt register}, core_data_load_o = 1.
  - Load counter with ROUND_CYCLES-1. Next state RUN.
- RUN:
  - Both strobes 0. core_data_o holds its last value.
  - Decrement counter each cycle.
  - In the cycle the counter is 0: capture core_data_i into ct_o; next state OUT.
- OUT:
  - ct_valid_o = 1; ct_o stays stable until handshake.
  - On ct_ready_i: ct_valid_o falls on the next edge; next state IDLE.
- ready outputs are 0 in KEY, DATA, RUN and OUT.
- Latency:
  - pt handshake at edge 0, DATA in cycle 1, RUN in cycles 2..ROUND_CYCLES+1.
  - ct_valid_o first high in cycle ROUND_CYCLES+2 (34 at default).
  - Back-to-back throughput is one block per ROUND_CYCLES+3 cycles when ct_ready_i is held at 1.
- Boundaries:
  - pt_valid_i before any key: stalls with no handshake.
  - A new key does not affect an in-flight block; it is accepted only in IDLE.
  - ct_ready_i while ct_valid_o is low: ignored.
  - ROUND_CYCLES must be ≥ 1; assert this at elaboration.

Optional Feature:
- Macro: PRESENT_CT_FIFO_EN.
- With the macro defined:
  - A 2-entry ciphertext FIFO replaces the OUT state.
  - RUN pushes the captured ciphertext and returns to IDLE.
  - ct_o/ct_valid_o come from the FIFO head.
  - pt_ready_o additionally requires FIFO count ≤ 1, so the push can never overflow.
  - A simultaneous push and pop at count 2 cannot occur; at count 1 it keeps count at 1.
  - Keys may be loaded while ciphertexts wait in the FIFO.
- Without the macro: the single register and OUT state apply, and IDLE is blocked until the ciphertext is consumed.

Decomposition:
- present_pkg holds:
  - KEY_W = 80, BLK_W = 64
  - ctrl_state_t enum
  - the four known-answer vectors (key, pt, ct) used by benches
- Sub-module present_ct_fifo: 2-deep, parameterised width, synchronous active-high reset, with count output. Instantiated only under PRESENT_CT_FIFO_EN.

Test Plan:
- Reset, then key 80'h0 and pt 64'h0, with ct_ready_i = 1 → ct_o = 64'h5579C1387B228445; ct_valid_o first rises exactly 34 cycles after the pt handshake.
- Key 80'hFFFF…FF, pt 64'h0 → 64'hE72C46C0F5945049. Key 80'h0, pt 64'hFFFF…FF → 64'hA112FFC72F68417B. Key all-ones, pt all-ones → 64'h3333DCD3213210D2.
- pt_valid_i held high after reset with no key → pt_ready_o stays 0 for 100 cycles, with no core strobes. Then present key and pt valid together → key loads first, then pt.
- ct_ready_i held at 0 for 20 cycles after ct_valid_o rises → ct_o stable, pt_ready_o = 0. Release → a single handshake, and ct_valid_o drops the next cycle.
- Assert rst_i in RUN cycle 10 → all outputs return to reset values next cycle, no ct_valid_o, and pt is refused until a key is reloaded.
- With PRESENT_CT_FIFO_EN and ct_ready_i = 0, submit three plaintexts → two are accepted and the third stalls. Drain → the ciphertexts emerge in order.
